if_fetch_ctrl: RTL
==================

Name: if_fetch_ctrl

Overview:
Fetch-stage sequencer that drives the SRAM-like instruction bus and holds the fetch-stage PC. It issues one request at a time, buffers the returned instruction until decode accepts it, and applies the decode-stage branch/jump target after the delay slot. It also applies exception/ERET flush targets immediately, cancelling any response already in flight.

Parameters:
RESET_PC, 32'hbfc00000, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
inst_req  output  1  instruction request valid
inst_wr  output  1  constant 0
inst_size  output  2  constant 2'b10 (word)
inst_addr  output  32  request address, equals pc
inst_addr_ok  input  1  request accepted this cycle
inst_data_ok  input  1  response valid this cycle
inst_rdata  input  32  response data
ds_allowin  input  1  decode accepts the fetch-stage instruction this cycle
fs_valid  output  1  fetch-stage instruction valid
fs_pc  output  32  address of the held instruction
fs_inst  output  32  held instruction
br_valid  input  1  taken branch/jump in decode; 1-cycle pulse
br_target  input  32  branch/jump target, qualified by br_valid
flush  input  1  exception/ERET redirect; 1-cycle pulse
flush_target  input  32  0xbfc00380 or EPC, qualified by flush

Behaviour:
- Registers: state, pc, inst_buf, cancel, br_pending, br_tgt.
- Reset (async) values: state=IDLE, pc=RESET_PC, cancel=0, br_pending=0, inst_buf=0. Resulting outputs: inst_req=0, fs_valid=0, fs_pc=RESET_PC, fs_inst=0.
- Outputs:
  - inst_req=(state==REQ); inst_addr=pc.
  - fs_valid=(state==HOLD); fs_pc=pc; fs_inst=inst_buf.
- nxt = br_pending ? br_tgt : pc+4. Addition is 32-bit and wraps modulo 2^32.
- At most one outstanding request. inst_addr is stable while inst_req=1 and addr_ok=0, except when flush changes it.
- States:
  - IDLE: next cycle go to REQ.
  - REQ: on addr_ok, go to WAIT.
  - WAIT: on data_ok with cancel=0, inst_buf<=rdata and go to HOLD. On data_ok with cancel=1, clear cancel and go to REQ; pc is already the redirect target.
  - HOLD: on ds_allowin, pc<=nxt, br_pending<=0, go to REQ.
- br_valid (delay-slot semantics):
  - The instruction at pc is the delay slot and is still delivered. br_pending<=1, br_tgt<=br_target.
  - br_valid in HOLD together with ds_allowin: pc<=br_target directly, br_pending stays 0.
  - A second br_valid before consumption overwrites br_tgt.
- flush has highest priority in every state:
  - pc<=flush_target, br_pending<=0, inst_buf discarded, go to REQ. From IDLE, flush also goes to REQ with pc=flush_target.
  - REQ without addr_ok: the address changes next cycle, no cancel.
  - REQ with addr_ok: go to WAIT, cancel<=1.
  - WAIT without data_ok: stay in WAIT, cancel<=1.
  - WAIT with data_ok: discard the response, go to REQ, cancel<=0.
  - HOLD, including with ds_allowin: the instruction is not delivered; go to REQ.
  - flush together with br_valid: flush wins, br ignored.
- Latency: minimum 3 cycles from REQ entry to fs_valid (REQ, WAIT, HOLD) with addr_ok and data_ok each in their first cycle.
- Reset mid-transaction: state returns to IDLE. A late data_ok after reset is ignored, because it arrives in IDLE or REQ.
- data_ok outside WAIT is ignored.

Test Plan:
- Reset released, addr_ok and data_ok each one cycle after issue, ds_allowin=1 -> inst_addr sequence 0xbfc00000, 0xbfc00004, 0xbfc00008; fs_valid pulses with matching fs_pc/fs_inst.
- Backpressure: ds_allowin=0 for 5 cycles in HOLD -> fs_valid, fs_pc and fs_inst stable, inst_req=0, no new request until ds_allowin=1.
- br_valid (target 0xbfc00100) while delay slot 0xbfc00008 is in WAIT -> 0xbfc00008 is delivered, then the next inst_addr is 0xbfc00100, then 0xbfc00104.
- flush (target 0xbfc00380) in WAIT, data_ok 2 cycles later with 0xdeadbeef -> 0xdeadbeef is never on fs_inst; the next request is 0xbfc00380, and its data is delivered with fs_pc=0xbfc00380.
- flush coincident with addr_ok in REQ -> cancel set, the first data_ok is dropped, the next inst_addr is flush_target; flush coincident with br_valid -> br ignored.
- pc=0xfffffffc sequential -> next inst_addr 0x00000000; reset asserted during WAIT -> outputs return to their reset values immediately, and the late data_ok is ignored.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: one outstanding instruction-bus request, a one-entry
// instruction buffer toward decode, delay-slot branch redirect and flush redirect.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        ds_allowin,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_target
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst_buf;
  logic        cancel;
  logic        br_pending;
  logic [31:0] br_tgt;
  logic [31:0] nxt;

  assign nxt       = br_pending ? br_tgt : pc + 32'd4;
  assign inst_req  = (state == REQ);
  assign inst_addr = pc;
  assign inst_wr   = 1'b0;
  assign inst_size = 2'b10;
  assign fs_valid  = (state == HOLD);
  assign fs_pc     = pc;
  assign fs_inst   = inst_buf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst_buf   <= 32'd0;
      cancel     <= 1'b0;
      br_pending <= 1'b0;
    end else if (flush) begin
      // Flush overrides everything; a response already in flight must be dropped.
      pc         <= flush_target;
      br_pending <= 1'b0;
      case (state)
        REQ: begin
          if (inst_addr_ok) begin
            state  <= WAIT;
            cancel <= 1'b1;
          end else begin
            state <= REQ;
          end
        end
        WAIT: begin
          if (inst_data_ok) begin
            state  <= REQ;
            cancel <= 1'b0;
          end else begin
            state  <= WAIT;
            cancel <= 1'b1;
          end
        end
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ:  if (inst_addr_ok) state <= WAIT;
        WAIT: begin
          if (inst_data_ok) begin
            if (cancel) begin
              cancel <= 1'b0;
              state  <= REQ;
            end else begin
              inst_buf <= inst_rdata;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (ds_allowin) begin
            pc    <= br_valid ? br_target : nxt;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
      // The instruction at pc is the delay slot; the target applies after it leaves.
      if (state == HOLD && ds_allowin)
        br_pending <= 1'b0;
      else if (br_valid)
        br_pending <= 1'b1;
    end
  end

  // Target payload is only meaningful while br_pending is set.
  always_ff @(posedge clk) begin
    if (br_valid && !flush)
      br_tgt <= br_target;
  end

endmodule
